instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch byte address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (power of two, >=2).
REQ-003 The block SHALL have parameter IMEM_SIZE_B, default 1024, meaning the instruction memory size in bytes.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port imem_pc_o, output, 32 bits, the byte address driven to the instruction memory read port.
REQ-007 The block SHALL have port imem_data_i, input, 32 bits, the memory read data, valid exactly one cycle after the address.
REQ-008 The block SHALL have ports redirect_i (input, 1) and redirect_pc_i (input, 32), the branch/jump request and its target.
REQ-009 The block SHALL have ports instr_valid_o (output, 1), instr_ready_i (input, 1), instr_o (output, 32) and instr_pc_o (output, 32), the decoder-side handshake.
REQ-010 The block SHALL have port fault_o, output, 1 bit, a sticky fetch fault.

Function
REQ-011 The block SHALL implement states RUN and FAULT; reset SHALL enter RUN.
REQ-012 In RUN, a fetch SHALL be issued in a cycle iff (buffer occupancy + in-flight count) < FIFO_DEPTH, or a buffer pop occurs in the same cycle.
REQ-013 imem_pc_o SHALL hold the fetch PC register; on an issue, the fetch PC SHALL advance by 4 (mod 2^32), and otherwise hold.
REQ-014 Data for an issued, non-discarded fetch SHALL be written to the buffer one cycle later, tagged with its address; memory data in non-issue cycles SHALL be ignored.
REQ-015 instr_valid_o SHALL be high iff the buffer is non-empty; instr_o/instr_pc_o SHALL present the head entry; a pop SHALL occur iff instr_valid_o && instr_ready_i.
REQ-016 With instr_ready_i held high, the block SHALL sustain one instruction per cycle; the first instr_valid_o SHALL occur 2 cycles after rst_i deasserts.
REQ-017 The buffer SHALL never overflow; a simultaneous push and pop on a full buffer SHALL keep occupancy unchanged.
REQ-018 redirect_i SHALL take priority over all other events: the buffer is flushed, any in-flight response is discarded, and the fetch PC loads redirect_pc_i; the next cycle issues redirect_pc_i.
REQ-019 A pop in the same cycle as a redirect SHALL still complete (the head is consumed), and instr_valid_o SHALL be low in the cycle after the redirect.
REQ-020 A redirect with redirect_pc_i[1:0] != 0 SHALL enter FAULT; in FAULT no fetches issue, the buffer is flushed, instr_valid_o=0, fault_o=1, and only reset exits.
REQ-021 A redirect in FAULT SHALL be ignored.

Reset
REQ-022 On rst_i the block SHALL set the fetch PC=RESET_PC, occupancy=0, in-flight=0, instr_valid_o=0, fault_o=0 and state=RUN; instr_o/instr_pc_o SHALL read 0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered and in-flight data in that cycle.

Configuration
REQ-024 With macro INSTR_FETCH_BOUND_CHECK_EN defined, an issue with fetch PC >= IMEM_SIZE_B SHALL instead enter FAULT, with no buffer write for that address.
REQ-025 Without INSTR_FETCH_BOUND_CHECK_EN, out-of-range fetches SHALL proceed normally and deliver whatever the memory returns (32'd0).

Verification
REQ-026 Reset release, ready=1, memory word=addr -> instr_pc_o 0,4,8,... on consecutive cycles, first valid 2 cycles after reset.
REQ-027 ready=0 for 5 cycles after the first valid -> occupancy stops at 2, imem_pc_o stalls at 0x8, no entry lost; ready=1 -> 0x0,0x4,0x8 delivered in order.
REQ-028 redirect_i with target 0x100 while the buffer is full and one fetch is in flight -> next valid has instr_pc_o=0x100, no stale PC appears.
REQ-029 redirect_pc_i=0x102 -> fault_o=1 next cycle, instr_valid_o=0, imem_pc_o frozen until rst_i.
REQ-030 With INSTR_FETCH_BOUND_CHECK_EN, redirect to 0x3FC -> 0x3FC delivered, then fault_o=1 and no 0x400 entry; without the macro, 0x400 is delivered with instr_o=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches to a 1-cycle
// memory, buffers tagged responses in a small FIFO and hands them to decode.
// Ports: clk_i/rst_i (sync, active-high); imem_pc_o/imem_data_i memory port;
// redirect_i/redirect_pc_i branch target; instr_valid_o/instr_ready_i/
// instr_o/instr_pc_o decode handshake; fault_o sticky fetch fault.
// Optional macro INSTR_FETCH_BOUND_CHECK_EN: fetches at or beyond
// IMEM_SIZE_B raise a fault instead of being issued.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 2,
    parameter int          IMEM_SIZE_B = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic           infl_q, infl_d;
    logic [31:0]    infl_pc_q, infl_pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW-1:0]  wr_q, wr_d;

    logic [31:0]    data_mem [FIFO_DEPTH];
    logic [31:0]    tag_mem  [FIFO_DEPTH];

    logic           valid;
    logic           pop;
    logic           push;
    logic           issue;
    logic           oob;
    logic [CW:0]    pending;

    assign valid   = (cnt_q != '0) && (state_q == RUN);
    assign pop     = valid && instr_ready_i;
    assign pending = {1'b0, cnt_q} + (CW+1)'(infl_q);

`ifdef INSTR_FETCH_BOUND_CHECK_EN
    assign oob = (pc_q >= 32'(IMEM_SIZE_B));
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        push      = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_i) begin
                    // Flush everything; the old in-flight word is dropped
                    // by leaving infl_d low.
                    cnt_d = '0;
                    rd_d  = '0;
                    wr_d  = '0;
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else begin
                    push  = infl_q;
                    issue = !oob &&
                            ((pending < (CW+1)'(FIFO_DEPTH)) || pop);
                    // Out-of-range fetch: let older entries drain first.
                    if (oob && (cnt_q == '0) && !infl_q) begin
                        state_d = FAULT;
                    end
                    if (issue) begin
                        pc_d      = pc_q + 32'd4;
                        infl_d    = 1'b1;
                        infl_pc_d = pc_q;
                    end
                    cnt_d = cnt_q + CW'(push) - CW'(pop);
                    if (push) wr_d = wr_q + AW'(1);
                    if (pop)  rd_d = rd_q + AW'(1);
                end
            end
            FAULT: begin
                cnt_d = '0;
                rd_d  = '0;
                wr_d  = '0;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    // Buffer storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            data_mem[wr_q] <= imem_data_i;
            tag_mem[wr_q]  <= infl_pc_q;
        end
    end

    assign imem_pc_o     = pc_q;
    assign instr_valid_o = valid;
    assign instr_o       = valid ? data_mem[rd_q] : '0;
    assign instr_pc_o    = valid ? tag_mem[rd_q] : '0;
    assign fault_o       = (state_q == FAULT);

endmodule
